// File: rtl/shift_mix_stage.sv
// AES ShiftRows + MixColumns round stage behind a two-entry valid/ready elastic buffer.
// The transform is combinational on the input side so both holding registers store finished results.
module shift_mix_stage #(
  parameter int TAG_W = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [0:127]     iState,
  input  logic             iLast,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [0:127]     oState,
  output logic             oLast,
  output logic [TAG_W-1:0] oTag,
  output logic [7:0]       oCount
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ready;
  logic             w_ready_next;
  logic [0:127]     r_out_state;
  logic [0:127]     r_skid_state;
  logic             r_out_last;
  logic             r_skid_last;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] r_skid_tag;
  logic [7:0]       r_count;

  logic             w_accept;
  logic             w_xfer;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;
  logic [0:127]     w_shift;
  logic [0:127]     w_mix;
  logic [0:127]     w_result;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at [32c+8r +: 8]; row r is rotated left by r columns.
  genvar gi, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign w_shift[32*gi+8*gr +: 8] = iState[32*((gi+gr)%4)+8*gr +: 8];
      end

      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_shift[32*gi +: 8];
      assign w_a1 = w_shift[32*gi+8 +: 8];
      assign w_a2 = w_shift[32*gi+16 +: 8];
      assign w_a3 = w_shift[32*gi+24 +: 8];

      assign w_mix[32*gi    +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_mix[32*gi+8  +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_mix[32*gi+16 +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_mix[32*gi+24 +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
  endgenerate

  assign w_result = iLast ? w_shift : w_mix;

  assign oValid   = (r_state != S_EMPTY);
  assign oReady   = r_ready;
  assign w_accept = iValid && r_ready;
  assign w_xfer   = oValid && iReady;

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next  = S_ONE;
          w_load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        case ({w_accept, w_xfer})
          2'b11: w_load_out_in = 1'b1;
          2'b10: begin
            w_state_next = S_FULL;
            w_load_skid  = 1'b1;
          end
          2'b01: w_state_next = S_EMPTY;
          default: w_state_next = S_ONE;
        endcase
      end
      S_FULL: begin
        if (w_xfer) begin
          w_state_next    = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
    // Ready is registered from the next state, so iReady never reaches oReady combinationally.
    w_ready_next = (w_state_next != S_FULL);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_ready <= w_ready_next;
      if (w_xfer) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_out_state  <= '0;
      r_out_last   <= 1'b0;
      r_out_tag    <= '0;
      r_skid_state <= '0;
      r_skid_last  <= 1'b0;
      r_skid_tag   <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out_state <= w_result;
        r_out_last  <= iLast;
        r_out_tag   <= iTag;
      end else if (w_load_out_skid) begin
        r_out_state <= r_skid_state;
        r_out_last  <= r_skid_last;
        r_out_tag   <= r_skid_tag;
      end
      if (w_load_skid) begin
        r_skid_state <= w_result;
        r_skid_last  <= iLast;
        r_skid_tag   <= iTag;
      end
    end
  end

  assign oState = r_out_state;
  assign oLast  = r_out_last;
  assign oTag   = r_out_tag;
  assign oCount = r_count;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Bench for shift_mix_stage: GF(2^8) reference model with a result queue checked every cycle,
// plus directed vectors with hand-computed results.
module tb_shift_mix_stage;
  localparam int TAG_W = 4;

  logic             iClk = 1'b0;
  logic             iRst = 1'b0;
  logic             iValid = 1'b0;
  logic             oReady;
  logic [0:127]     iState = '0;
  logic             iLast = 1'b0;
  logic [TAG_W-1:0] iTag = '0;
  logic             oValid;
  logic             iReady = 1'b1;
  logic [0:127]     oState;
  logic             oLast;
  logic [TAG_W-1:0] oTag;
  logic [7:0]       oCount;

  shift_mix_stage #(.TAG_W(TAG_W)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iState(iState), .iLast(iLast), .iTag(iTag), .oValid(oValid),
    .iReady(iReady), .oState(oState), .oLast(oLast), .oTag(oTag),
    .oCount(oCount)
  );

  always #5 iClk = ~iClk;

  localparam logic [127:0] GOLD_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] GOLD_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] GOLD_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] COL_IN   = {4{32'hdb135345}};
  localparam logic [127:0] COL_OUT  = {4{32'h8e4da1bc}};

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [127:0]     st;
    logic             last;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t       q[$];
  logic       m_rdy = 1'b0;
  logic [7:0] m_cnt = 8'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] v, input int r, input int c);
    return v[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [7:0] coef(input int r, input int k);
    case ((k - r + 4) % 4)
      0: return 8'd2;
      1: return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] xform(input logic [127:0] v, input logic last);
    logic [127:0] sr = '0;
    logic [127:0] o = '0;
    logic [7:0]   acc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[127-8*(4*c+r) -: 8] = getb(v, r, (c + r) % 4);
    if (last) return sr;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef(r, k), getb(sr, k, c));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // Per-cycle compare: the queue holds results accepted but not yet delivered.
  always @(negedge iClk) begin
    logic xf;
    logic ac;
    exp_t e;
    if (iRst) begin
      q.delete();
      m_cnt = 8'd0;
      m_rdy = 1'b0;
      chk("rst_valid", 128'(oValid), 128'd0);
      chk("rst_ready", 128'(oReady), 128'd0);
      chk("rst_count", 128'(oCount), 128'd0);
      chk("rst_state", oState, 128'd0);
      chk("rst_lasttag", 128'({oLast, oTag}), 128'd0);
    end else begin
      chk("valid", 128'(oValid), 128'(q.size() != 0));
      chk("ready", 128'(oReady), 128'(m_rdy));
      chk("count", 128'(oCount), 128'(m_cnt));
      if (q.size() != 0) begin
        chk("state", oState, q[0].st);
        chk("last", 128'(oLast), 128'(q[0].last));
        chk("tag", 128'(oTag), 128'(q[0].tag));
      end
      xf = (q.size() != 0) && iReady;
      ac = m_rdy && iValid;
      if (xf) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 8'd1;
      end
      if (ac) begin
        e.st   = xform(iState, iLast);
        e.last = iLast;
        e.tag  = iTag;
        q.push_back(e);
      end
      m_rdy = (q.size() < 2);
    end
  end

  task automatic send(input logic [127:0] st, input logic last, input logic [TAG_W-1:0] tag);
    logic acc;
    int n = 0;
    iValid = 1'b1;
    iState = st;
    iLast  = last;
    iTag   = tag;
    do begin
      acc = oReady;
      @(posedge iClk);
      #1;
      n++;
    end while (!acc && n < 100);
    iValid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got oReady=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic do_reset;
    iRst   = 1'b1;
    iValid = 1'b1;
    iState = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    #1;
    chk("rst_now_valid", 128'(oValid), 128'd0);
    chk("rst_now_count", 128'(oCount), 128'd0);
    chk("rst_now_state", oState, 128'd0);
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_hold_ready", 128'(oReady), 128'd0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    chk("post_rst_ready", 128'(oReady), 128'd1);
    chk("post_rst_nocapture", 128'(oValid), 128'd0);
  endtask

  initial begin
    chk("model_mix", xform(GOLD_IN, 1'b0), GOLD_MIX);
    chk("model_sr", xform(GOLD_IN, 1'b1), GOLD_SR);
    chk("model_col", xform(COL_IN, 1'b0), COL_OUT);

    #2;
    do_reset();

    iReady = 1'b1;
    send(GOLD_IN, 1'b0, 4'h1);
    chk("fips_mix_valid", 128'(oValid), 128'd1);
    chk("fips_mix_state", oState, GOLD_MIX);

    send(GOLD_IN, 1'b1, 4'hA);
    chk("fips_sr_state", oState, GOLD_SR);
    chk("fips_sr_last", 128'(oLast), 128'd1);
    chk("fips_sr_tag", 128'(oTag), 128'hA);

    send(COL_IN, 1'b0, 4'h3);
    chk("column_state", oState, COL_OUT);
    chk("column_count", 128'(oCount), 128'd2);

    // Backpressure: two fill the buffer, the third waits upstream.
    do_reset();
    iReady = 1'b0;
    send(GOLD_IN, 1'b0, 4'h4);
    send(GOLD_IN, 1'b1, 4'h5);
    iValid = 1'b1;
    iState = COL_IN;
    iLast  = 1'b0;
    iTag   = 4'h6;
    repeat (3) @(posedge iClk);
    #1;
    chk("bp_ready_low", 128'(oReady), 128'd0);
    chk("bp_state_held", oState, GOLD_MIX);
    iReady = 1'b1;
    send(COL_IN, 1'b0, 4'h6);
    send(GOLD_IN, 1'b1, 4'h7);
    repeat (3) @(posedge iClk);
    #1;
    chk("bp_count", 128'(oCount), 128'd4);
    chk("bp_drained", 128'(oValid), 128'd0);

    // Reset while FULL.
    iReady = 1'b0;
    send(COL_IN, 1'b0, 4'h8);
    send(GOLD_IN, 1'b0, 4'h9);
    chk("full_ready_low", 128'(oReady), 128'd0);
    do_reset();
    iReady = 1'b1;
    send(COL_IN, 1'b0, 4'hB);
    chk("after_full_rst_valid", 128'(oValid), 128'd1);
    chk("after_full_rst_state", oState, COL_OUT);
    @(posedge iClk);
    #1;

    // Full throughput with counter wrap.
    do_reset();
    iReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      iValid = 1'b1;
      iState = {$urandom, $urandom, $urandom, $urandom};
      iLast  = i[0];
      iTag   = i[3:0];
      @(posedge iClk);
      #1;
    end
    iValid = 1'b0;
    @(posedge iClk);
    #1;
    chk("thru_count_wrap", 128'(oCount), 128'd44);
    chk("thru_drained", 128'(oValid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
